// File: rtl/hm_tx_sched.sv
// Packet-atomic round-robin scheduler: N requesters share one TRN transmit path; grant 1 cycle after req, 1-cycle GAP between packets.
// Backpressure: out_ready passes combinationally to the granted src_ready; watchdog and beat limit force release of a stuck grant.
module hm_tx_sched #(
  parameter int N         = 5,
  parameter int DW        = 64,
  parameter int MAX_BEATS = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                 trn_clk,
  input  logic                 trn_rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         src_valid,
  input  logic [N-1:0]         src_last,
  input  logic [N*DW-1:0]      src_data,
  output logic [N-1:0]         src_ready,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [DW-1:0]        out_data,
  input  logic                 out_ready,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy,
  output logic                 err_tmo,
  output logic                 err_ovf
);

  localparam int IW = $clog2(N);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_gnt;
  logic [IW-1:0]   r_gnt_idx;
  logic [IW-1:0]   r_ptr;
  logic            r_busy;
  logic            r_err_tmo;
  logic            r_err_ovf;
  logic [BW-1:0]   r_beat_cnt;
  logic [SW-1:0]   r_stall_cnt;

  logic            w_sel_valid;
  logic            w_sel_last;
  logic [DW-1:0]   w_sel_data;
  logic            w_accept;
  logic            w_arb_found;
  logic [IW-1:0]   w_arb_idx;
  logic [N-1:0]    w_arb_onehot;
  int              w_dist;
  int              w_best_d;
  logic            w_grant;
  logic            w_release;
  logic            w_tmo_nxt;
  logic            w_ovf_nxt;

  // Source mux keyed on the registered grant index.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (r_gnt_idx == IW'(i)) begin
        w_sel_valid = src_valid[i];
        w_sel_last  = src_last[i];
        w_sel_data  = src_data[i*DW +: DW];
      end
    end
  end

  assign out_valid = r_busy & w_sel_valid;
  assign out_last  = r_busy & w_sel_last;
  assign out_data  = r_busy ? w_sel_data : '0;
  assign src_ready = r_gnt & {N{out_ready}};
  assign w_accept  = out_valid & out_ready;

  // Rotating priority: distance 0 is the requester right after the last winner.
  always_comb begin
    w_arb_idx = '0;
    w_best_d  = N;
    w_dist    = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - 1 - int'(r_ptr)) % N;
      if (req[i] && (w_dist < w_best_d)) begin
        w_best_d  = w_dist;
        w_arb_idx = IW'(i);
      end
    end
  end

  assign w_arb_found = |req;

  always_comb begin
    w_arb_onehot = '0;
    for (int i = 0; i < N; i++) begin
      w_arb_onehot[i] = (w_arb_idx == IW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    w_tmo_nxt   = 1'b0;
    w_ovf_nxt   = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (w_arb_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_XFER;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_XFER: begin
        // A last beat outranks both limits in the same cycle.
        if (w_accept && w_sel_last) begin
          w_release   = 1'b1;
          w_state_nxt = S_GAP;
        end else if (w_accept && (r_beat_cnt == BW'(MAX_BEATS - 1))) begin
          w_release   = 1'b1;
          w_ovf_nxt   = 1'b1;
          w_state_nxt = S_GAP;
        end else if (!w_accept && (r_stall_cnt == SW'(TIMEOUT - 1))) begin
          w_release   = 1'b1;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge trn_clk or negedge trn_rst_n) begin
    if (!trn_rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_ptr       <= IW'(N - 1);
      r_busy      <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_err_tmo <= w_tmo_nxt;
      r_err_ovf <= w_ovf_nxt;
      if (w_grant) begin
        r_gnt       <= w_arb_onehot;
        r_gnt_idx   <= w_arb_idx;
        r_ptr       <= w_arb_idx;
        r_busy      <= 1'b1;
        r_beat_cnt  <= '0;
        r_stall_cnt <= '0;
      end else if (w_release) begin
        r_gnt  <= '0;
        r_busy <= 1'b0;
      end else if (r_state == S_XFER) begin
        if (w_accept) begin
          r_beat_cnt  <= r_beat_cnt + BW'(1);
          r_stall_cnt <= '0;
        end else begin
          r_stall_cnt <= r_stall_cnt + SW'(1);
        end
      end
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign busy    = r_busy;
  assign err_tmo = r_err_tmo;
  assign err_ovf = r_err_ovf;

  a_gnt_onehot0: assert property (@(posedge trn_clk) disable iff (!trn_rst_n) $onehot0(r_gnt));
  a_gnt_stable:  assert property (@(posedge trn_clk) disable iff (!trn_rst_n)
                   (r_state == S_XFER && w_state_nxt == S_XFER) |=> $stable(r_gnt));

endmodule

// File: tb/tb_hm_tx_sched.sv
// Bench for hm_tx_sched: scripted/random requesters, a per-cycle transaction model of the
// arbiter, and directed phases for fairness, backpressure, watchdog, overflow, req drop and reset.
module tb_hm_tx_sched;
  localparam int N = 5, DW = 64, MAX_BEATS = 32, TIMEOUT = 256, IW = 3;

  logic            trn_clk = 1'b0;
  logic            trn_rst_n;
  logic [N-1:0]    req, src_valid, src_last, src_ready, gnt;
  logic [N*DW-1:0] src_data;
  logic            out_valid, out_last, out_ready, busy, err_tmo, err_ovf;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   gnt_idx;

  hm_tx_sched #(.N(N), .DW(DW), .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)) dut (
    .trn_clk(trn_clk), .trn_rst_n(trn_rst_n), .req(req), .src_valid(src_valid),
    .src_last(src_last), .src_data(src_data), .src_ready(src_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .err_tmo(err_tmo), .err_ovf(err_ovf));

  always #5 trn_clk = ~trn_clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Requester scripts
  int plen[N], bidx[N], vpct[N], npkt[N], pseq[N];
  bit nolast[N], drop[N];
  int rdy_mode = 0;
  bit rdy_tog  = 1'b0;

  // Model state and event logs
  int m_owner = -1, m_last = N - 1, m_beats = 0, m_stall = 0;
  bit m_tmo = 1'b0, m_ovf = 1'b0;
  int cyc = 0;
  int g_who[$], g_cyc[$], rel_cyc[$];
  int n_tmo = 0, n_ovf = 0, tmo_cyc = 0;
  int acc_cnt[N];

  task automatic load(input int i, input int len, input int vp, input int np, input bit nl, input bit dr);
    plen[i] = len; bidx[i] = 0; vpct[i] = vp; npkt[i] = np; nolast[i] = nl; drop[i] = dr;
    pseq[i]++;
  endtask

  task automatic clear_logs();
    g_who.delete(); g_cyc.delete(); rel_cyc.delete();
    n_tmo = 0; n_ovf = 0; tmo_cyc = 0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
  endtask

  task automatic end_packet(input int o);
    rel_cyc.push_back(cyc);
    bidx[o] = 0;
    if (npkt[o] > 0) begin
      npkt[o]--;
      pseq[o]++;
    end else begin
      plen[o] = 0;
    end
    m_owner = -1;
  endtask

  // Input driver
  initial begin
    bit has;
    forever begin
      @(posedge trn_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        has          = plen[i] > 0;
        req[i]       = has && !(drop[i] && bidx[i] > 0);
        src_valid[i] = has && (int'($urandom_range(99)) < vpct[i]);
        src_last[i]  = has && !nolast[i] && (bidx[i] == plen[i] - 1);
        src_data[i*DW +: DW] = {8'(i), 24'(pseq[i]), 32'(bidx[i])};
      end
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = rdy_tog; rdy_tog = !rdy_tog; end
        default: out_ready = int'($urandom_range(99)) < 80;
      endcase
    end
  end

  // Compare process: check outputs against the model, then advance the model
  initial begin
    bit eb, acc;
    logic [N-1:0] eg;
    int c;
    forever begin
      @(negedge trn_clk);
      cyc++;
      if (!trn_rst_n) begin
        m_owner = -1; m_last = N - 1; m_tmo = 1'b0; m_ovf = 1'b0;
        chk("rst_gnt", gnt, 0);
        chk("rst_gnt_idx", gnt_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_errs", {err_tmo, err_ovf}, 0);
      end else begin
        eb = m_owner >= 0;
        eg = eb ? (N'(1) << m_owner) : '0;
        chk("gnt", gnt, eg);
        chk("busy", busy, eb);
        chk("err_tmo", err_tmo, m_tmo);
        chk("err_ovf", err_ovf, m_ovf);
        chk("out_valid", out_valid, eb ? src_valid[m_owner] : 1'b0);
        chk("out_last", out_last, eb ? src_last[m_owner] : 1'b0);
        chk("src_ready", src_ready, (eb && out_ready) ? eg : '0);
        if (eb) begin
          chk("gnt_idx", gnt_idx, m_owner);
          chk("out_data", out_data, src_data[m_owner*DW +: DW]);
        end
        m_tmo = 1'b0;
        m_ovf = 1'b0;
        if (eb) begin
          acc = src_valid[m_owner] && out_ready;
          if (acc) begin
            m_beats++; m_stall = 0; acc_cnt[m_owner]++; bidx[m_owner]++;
          end else begin
            m_stall++;
          end
          if (acc && src_last[m_owner]) begin
            end_packet(m_owner);
          end else if (acc && m_beats == MAX_BEATS) begin
            m_ovf = 1'b1; n_ovf++;
            end_packet(m_owner);
          end else if (!acc && m_stall == TIMEOUT) begin
            m_tmo = 1'b1; n_tmo++; tmo_cyc = cyc + 1;
            end_packet(m_owner);
          end
        end else begin
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (m_owner < 0 && req[c]) begin
              m_owner = c; m_last = c; m_beats = 0; m_stall = 0;
              g_who.push_back(c);
              g_cyc.push_back(cyc + 1);
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input int maxc, input string nm);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < maxc) begin
      @(negedge trn_clk);
      #1;
      n++;
      done = (m_owner < 0);
      for (int i = 0; i < N; i++) if (plen[i] != 0) done = 1'b0;
    end
    repeat (3) @(negedge trn_clk);
    #1;
    chk({nm, "_drain"}, done, 1);
  endtask

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 4, 0};
    req = '0; src_valid = '0; src_last = '0; src_data = '0; out_ready = 1'b0;
    trn_rst_n = 1'b0;
    repeat (3) @(posedge trn_clk);
    #1 trn_rst_n = 1'b1;

    // Fairness: everyone requests, 2-beat packets, requester 0 has two packets
    @(negedge trn_clk); #1;
    clear_logs();
    rdy_mode = 0;
    for (int i = 0; i < N; i++) load(i, 2, 100, (i == 0) ? 1 : 0, 1'b0, 1'b0);
    wait_idle(200, "fair");
    chk("fair_count", g_who.size(), 6);
    if (g_who.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk($sformatf("fair_order%0d", k), g_who[k], exp_order[k]);
      chk("fair_step", g_cyc[1] - g_cyc[0], 3);
      chk("fair_round", g_cyc[5] - g_cyc[0], 15);
    end

    // Backpressure: requester 2, 4 beats, out_ready 1,0,1,0... during XFER
    clear_logs();
    rdy_tog = 1'b0; rdy_mode = 1;
    load(2, 4, 100, 0, 1'b0, 1'b0);
    wait_idle(100, "bp");
    chk("bp_beats", acc_cnt[2], 4);
    chk("bp_grants", g_who.size(), 1);
    if (g_who.size() >= 1 && rel_cyc.size() >= 1) begin
      chk("bp_who", g_who[0], 2);
      chk("bp_hold", rel_cyc[0] - g_cyc[0], 6);
    end

    // Watchdog: requester 1 never sends, requester 2 waits behind it
    clear_logs();
    rdy_mode = 0;
    load(1, 3, 0, 0, 1'b0, 1'b0);
    load(2, 2, 100, 0, 1'b0, 1'b0);
    wait_idle(700, "wd");
    chk("wd_tmo_count", n_tmo, 1);
    chk("wd_ovf_count", n_ovf, 0);
    chk("wd_grants", g_who.size(), 2);
    if (g_who.size() >= 2) begin
      chk("wd_first", g_who[0], 1);
      chk("wd_next", g_who[1], 2);
      chk("wd_tmo_delay", tmo_cyc - g_cyc[0], 256);
      chk("wd_regrant", g_cyc[1] - g_cyc[0], 257);
    end

    // Overflow: 40 beats without last, then 32 beats with last on beat 32
    clear_logs();
    load(3, 40, 100, 0, 1'b1, 1'b0);
    wait_idle(200, "ovf");
    chk("ovf_beats", acc_cnt[3], 32);
    chk("ovf_count", n_ovf, 1);
    if (g_who.size() >= 1 && rel_cyc.size() >= 1) chk("ovf_hold", rel_cyc[0] - g_cyc[0], 31);
    clear_logs();
    load(3, 32, 100, 0, 1'b0, 1'b0);
    wait_idle(200, "ovf32");
    chk("ovf32_beats", acc_cnt[3], 32);
    chk("ovf32_count", n_ovf, 0);

    // Req drop after first beat: grant must hold for all 3 beats
    clear_logs();
    load(0, 3, 100, 0, 1'b0, 1'b1);
    load(1, 2, 100, 0, 1'b0, 1'b0);
    wait_idle(100, "drop");
    chk("drop_beats", acc_cnt[0], 3);
    chk("drop_grants", g_who.size(), 2);
    if (g_who.size() >= 2) begin
      chk("drop_first", g_who[0], 0);
      chk("drop_second", g_who[1], 1);
      chk("drop_hold", g_cyc[1] - g_cyc[0], 4);
    end

    // Asynchronous reset mid-packet
    clear_logs();
    load(2, 10, 100, 0, 1'b0, 1'b0);
    repeat (5) @(negedge trn_clk);
    @(posedge trn_clk);
    #3 trn_rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    for (int i = 0; i < N; i++) begin plen[i] = 0; bidx[i] = 0; end
    load(0, 2, 100, 0, 1'b0, 1'b0);
    @(posedge trn_clk);
    #1 trn_rst_n = 1'b1;
    @(posedge trn_clk);
    #2;
    chk("arst_regrant", gnt, 5'b00001);
    wait_idle(100, "arst");

    // Randomized traffic
    clear_logs();
    rdy_mode = 2;
    repeat (3000) begin
      @(negedge trn_clk); #1;
      for (int i = 0; i < N; i++) begin
        if (plen[i] == 0 && $urandom_range(7) == 0) begin
          int r;
          r = int'($urandom_range(99));
          load(i, int'($urandom_range(36, 1)), (r < 2) ? 0 : ((r < 50) ? 100 : 60), 0,
               $urandom_range(15) == 0, $urandom_range(3) == 0);
        end
      end
    end
    wait_idle(3000, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
